// File: rtl/sonar_pkg.sv
// Shared types and 50 MHz defaults for the ultrasonic measurement path.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE,
    ST_TOUT
  } state_e;

  localparam int DEF_TRIG_CYC    = 500;
  localparam int DEF_CYC_PER_CM  = 2900;
  localparam int DEF_TIMEOUT_CYC = 1_250_000;
  localparam int DEF_GAP_CYC     = 3_000_000;
  localparam int DEF_CLOSE_CM    = 7;
  localparam int DEF_OPEN_CM     = 10;
  localparam int DEF_FAULT_N     = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the sensor echo with registered rise/fall pulses.
module echo_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic echo_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  // level_o is delayed one stage so it lines up with the edge pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Ultrasonic measurement sequencer: trigger, echo timing, cm conversion,
// timeout/fault tracking and servo close/open hysteresis.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int CLOSE_CM    = DEF_CLOSE_CM,
  parameter int OPEN_CM     = DEF_OPEN_CM,
  parameter int FAULT_N     = DEF_FAULT_N
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance,
  output logic        dist_valid,
  output logic        timeout,
  output logic        fault,
  output logic        close_cmd,
  output logic        busy
);

  localparam int CNT_W    = $clog2(max3(GAP_CYC, TIMEOUT_CYC, TRIG_CYC) + 1);
  localparam int SUB_W    = $clog2(CYC_PER_CM + 1);
  localparam int STREAK_W = $clog2(FAULT_N + 1);

  localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]    TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0]    TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SUB_W-1:0]    SUB_LAST  = SUB_W'(CYC_PER_CM - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAULT_N);

  logic echo_lvl, echo_rise, echo_fall;

  echo_sync u_echo_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .echo_i (echo),
    .level_o(echo_lvl),
    .rise_o (echo_rise),
    .fall_o (echo_fall)
  );

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SUB_W-1:0]     sub_q;
  logic [15:0]          cm_q;
  logic [STREAK_W-1:0]  streak_q;
  logic                 trig_q, dist_valid_q, timeout_q, fault_q, close_q, busy_q;
  logic [15:0]          distance_q;

  logic                 sub_wrap;
  logic [SUB_W-1:0]     sub_d;
  logic [15:0]          cm_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [STREAK_W-1:0]  streak_d;

  // Divider-free conversion: every CYC_PER_CM high cycles bumps the cm count
  always_comb begin
    sub_wrap = (sub_q == SUB_LAST);
    sub_d    = sub_wrap ? '0 : sub_q + 1'b1;
    cm_d     = (sub_wrap && cm_q != 16'hFFFF) ? cm_q + 16'd1 : cm_q;
    cnt_d    = cnt_q + 1'b1;
    streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
  end

  // One shared cycle counter serves gap, trigger, rise wait and echo length
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      cnt_q        <= GAP_LAST;
      sub_q        <= '0;
      cm_q         <= '0;
      streak_q     <= '0;
      trig_q       <= 1'b0;
      distance_q   <= '0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      fault_q      <= 1'b0;
      close_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_TRIG;
            cnt_q   <= '0;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            state_q <= ST_WAIT_RISE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            sub_q   <= '0;
            cm_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WAIT_RISE: begin
          // The rise cycle itself is the first high cycle of the echo
          if (echo_rise) begin
            state_q <= ST_MEASURE;
            cnt_q   <= CNT_W'(1);
            sub_q   <= sub_d;
            cm_q    <= cm_d;
          end else if (cnt_q == TOUT_LAST) begin
            state_q   <= ST_TOUT;
            timeout_q <= 1'b1;
            streak_q  <= streak_d;
            fault_q   <= (streak_d == STREAK_MAX);
            close_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_MEASURE: begin
          if (echo_fall) begin
            state_q      <= ST_DONE;
            distance_q   <= cm_q;
            dist_valid_q <= 1'b1;
            streak_q     <= '0;
            fault_q      <= 1'b0;
            if (cm_q <= 16'(CLOSE_CM)) begin
              close_q <= 1'b1;
            end else if (cm_q >= 16'(OPEN_CM)) begin
              close_q <= 1'b0;
            end
          end else if (echo_lvl) begin
            sub_q <= sub_d;
            cm_q  <= cm_d;
            if (cnt_q == TOUT_LAST) begin
              state_q   <= ST_TOUT;
              timeout_q <= 1'b1;
              streak_q  <= streak_d;
              fault_q   <= (streak_d == STREAK_MAX);
              close_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        ST_DONE, ST_TOUT: begin
          state_q <= ST_GAP;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_GAP;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig       = trig_q;
  assign distance   = distance_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;
  assign fault      = fault_q;
  assign close_cmd  = close_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with small cycle constants.
module tb_sonar_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        echo;
  logic        trig;
  logic [15:0] distance;
  logic        dist_valid;
  logic        timeout;
  logic        fault;
  logic        close_cmd;
  logic        busy;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .TRIG_CYC   (4),
    .CYC_PER_CM (10),
    .TIMEOUT_CYC(1000),
    .GAP_CYC    (200),
    .CLOSE_CM   (7),
    .OPEN_CM    (10),
    .FAULT_N    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .echo      (echo),
    .trig      (trig),
    .distance  (distance),
    .dist_valid(dist_valid),
    .timeout   (timeout),
    .fault     (fault),
    .close_cmd (close_cmd),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the first negedge with trig low after a trigger pulse
  task automatic waitTrigger();
    int n;
    n = 0;
    while (trig !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trig_seen", 32'(trig === 1'b1), 32'd1);
    n = 0;
    while (trig !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trig_end", 32'(trig === 1'b0), 32'd1);
  endtask

  // Drives an echo of len cycles starting 3 cycles in, watches for a result
  task automatic applyStimulus(input int len, input bit holdHigh,
                               output int tSeen, output bit gotValid, output bit gotTout);
    tSeen    = -1;
    gotValid = 1'b0;
    gotTout  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      echo = holdHigh || (len > 0 && c >= 3 && c < 3 + len);
      if (tSeen < 0 && (dist_valid === 1'b1 || timeout === 1'b1)) begin
        tSeen    = c;
        gotValid = dist_valid;
        gotTout  = timeout;
      end
      if (tSeen >= 0 && c >= 3 + len) break;
      @(negedge clk);
    end
  endtask

  task automatic runMeasure(input string tag, input int len, input bit holdHigh,
                            input bit expValid, input int expDist, input bit expClose,
                            input bit expFault, input int expCycle);
    int tSeen;
    bit gotValid, gotTout;
    applyStimulus(len, holdHigh, tSeen, gotValid, gotTout);
    checkOutput({tag, "_event"}, {30'd0, gotValid, gotTout}, {30'd0, expValid, ~expValid});
    checkOutput({tag, "_dist"}, 32'(distance), 32'(expDist));
    checkOutput({tag, "_close"}, 32'(close_cmd), 32'(expClose));
    checkOutput({tag, "_fault"}, 32'(fault), 32'(expFault));
    if (expCycle >= 0) checkOutput({tag, "_cycle"}, 32'(tSeen), 32'(expCycle));
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {30'd0, dist_valid, timeout}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", {trig, distance, dist_valid, timeout, fault, close_cmd, busy}, 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rel_trig%0d", i), 32'(trig), (i < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rel_quiet%0d", i),
                  {distance, dist_valid, timeout, fault, close_cmd}, 32'd0);
    end

    runMeasure("m55", 55, 1'b0, 1'b1, 5, 1'b1, 1'b0, 62);

    waitTrigger(); runMeasure("m120", 120, 1'b0, 1'b1, 12, 1'b0, 1'b0, 127);
    waitTrigger(); runMeasure("m85a", 85, 1'b0, 1'b1, 8, 1'b0, 1'b0, 92);
    waitTrigger(); runMeasure("m100", 100, 1'b0, 1'b1, 10, 1'b0, 1'b0, 107);
    waitTrigger(); runMeasure("m50", 50, 1'b0, 1'b1, 5, 1'b1, 1'b0, 57);
    waitTrigger(); runMeasure("m85b", 85, 1'b0, 1'b1, 8, 1'b1, 1'b0, 92);

    for (int k = 0; k < 3; k++) begin
      waitTrigger();
      runMeasure($sformatf("noecho%0d", k), 0, 1'b0, 1'b0, 8, 1'b0, (k == 2), 1000);
    end
    waitTrigger(); runMeasure("m30", 30, 1'b0, 1'b1, 3, 1'b1, 1'b0, 37);

    echo = 1'b1;
    waitTrigger(); runMeasure("stuck", 0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1000);
    echo = 1'b0;

    waitTrigger(); runMeasure("long", 1500, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1006);

    waitTrigger();
    echo = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst", {trig, distance, dist_valid, timeout, fault, close_cmd, busy}, 32'd0);
    rst_n = 1'b1;
    echo  = 1'b0;
    @(negedge clk);
    checkOutput("mid_retrig", {30'd0, trig, busy}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
